muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 138 +++++++++++++
 tb/tb_muldiv_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Sequential unsigned multiply/divide unit writing its result straight into the register file.
// Latency: done/wrenable pulse 16 cycles after the accepting edge; the next start is accepted one cycle after WB.
// Backpressure: busy is high through RUN and WB; start is ignored while busy (there is no queueing).
module muldiv_unit #(
  parameter int WIDTH = 16,
  parameter int ADW   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [ADW-1:0]   dest,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] wr,
  output logic [ADW-1:0]   a3,
  output logic             wrenable
);

  typedef enum logic [1:0] {IDLE, RUN, WB} state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;   // multiplicand (MUL) or divisor (DIV)
  logic [WIDTH-1:0] hi_q, hi_d;       // product high half / partial remainder
  logic [WIDTH-1:0] lo_q, lo_d;       // multiplier then product low half / dividend then quotient
  logic [ADW-1:0]   dest_q, dest_d;
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] wr_q, wr_d;
  logic [ADW-1:0]   a3_q, a3_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;
  logic             rem_ge;
  logic [WIDTH-1:0] step_hi, step_lo;

  // One datapath iteration: shift-add multiply or restoring divide step.
  // The partial remainder stays below the divisor (or is a dividend prefix when the
  // divisor is zero), so the sign bit of the WIDTH+1 subtraction is a valid compare.
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    rem_sh   = {hi_q, lo_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, opnd_q};
    rem_ge   = ~rem_diff[WIDTH];
    step_hi  = '0;
    step_lo  = '0;
    if (op_q[1]) begin
      step_hi = rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], rem_ge};
    end else begin
      {step_hi, step_lo} = {mul_sum, lo_q[WIDTH-1:1]};
    end
  end

  // Next-state and register-load decode for the IDLE/RUN/WB sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dest_d  = dest_q;
    div0_d  = div0_q;
    wr_d    = wr_q;
    a3_d    = a3_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = 4'd0;
          op_d    = op;
          opnd_d  = op[1] ? srcb : srca;
          lo_d    = op[1] ? srca : srcb;
          hi_d    = '0;
          dest_d  = dest;
          div0_d  = op[1] && (srcb == '0);
        end
      end
      RUN: begin
        cnt_d = cnt_q + 4'd1;
        hi_d  = step_hi;
        lo_d  = step_lo;
        if (cnt_q == 4'd15) begin
          state_d = WB;
          // MULH and REM live in the high half, MUL low and quotient in the low half.
          wr_d    = op_q[0] ? step_hi : step_lo;
          a3_d    = dest_q;
        end
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dest_q  <= '0;
      div0_q  <= 1'b0;
      wr_q    <= '0;
      a3_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dest_q  <= dest_d;
      div0_q  <= div0_d;
      wr_q    <= wr_d;
      a3_q    <= a3_d;
    end
  end

  // Outputs decoded from registered state only; register 0 is never written.
  always_comb begin
    busy     = (state_q != IDLE);
    done     = (state_q == WB);
    div0     = (state_q == WB) && div0_q;
    wrenable = (state_q == WB) && (dest_q != '0);
    wr       = wr_q;
    a3       = a3_q;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, corner sequences, random ops.
// Latency: each operation is expected to complete 16 cycles after acceptance.
// Backpressure: the bench waits for completion before issuing the next start.
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [15:0] srca;
  logic [15:0] srcb;
  logic [2:0]  dest;
  logic        busy;
  logic        done;
  logic        div0;
  logic [15:0] wr;
  logic [2:0]  a3;
  logic        wrenable;

  int checks   = 0;
  int failures = 0;

  muldiv_unit #(.WIDTH(16), .ADW(3)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
    .dest(dest), .busy(busy), .done(done), .div0(div0), .wr(wr), .a3(a3),
    .wrenable(wrenable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  d;
    logic [15:0] exp_wr;
    logic        exp_div0;
  } vec_t;

  // Reference result from plain arithmetic: {div0, result}.
  function automatic logic [16:0] model(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    p = 32'(a) * 32'(b);
    case (o)
      2'b00:   return {1'b0, p[15:0]};
      2'b01:   return {1'b0, p[31:16]};
      2'b10:   return (b == 16'd0) ? {1'b1, 16'hFFFF} : {1'b0, a / b};
      default: return (b == 16'd0) ? {1'b1, a} : {1'b0, a % b};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Present an operation for one edge, then scramble the operand inputs.
  task automatic launch(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b, input logic [2:0] d);
    op = o; srca = a; srcb = b; dest = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op   = 2'($urandom);
    srca = 16'($urandom);
    srcb = 16'($urandom);
    dest = 3'($urandom);
  endtask

  // Wait for done (bounded), then check the WB-cycle outputs. Returns inside the WB cycle.
  task automatic check_result(input int elapsed, input logic [15:0] exp_wr, input logic exp_div0,
                              input logic [2:0] exp_a3, input string tag);
    int cyc;
    int wen;
    bit busy_ok;
    cyc = elapsed; wen = 0; busy_ok = 1'b1;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (wrenable) wen++;
      if (!busy) busy_ok = 1'b0;
    end
    if (!done) begin
      chk({tag, " done timeout"}, 32'(done), 32'd1);
    end else begin
      chk({tag, " latency"}, 32'(cyc), 32'd16);
      chk({tag, " wr"}, 32'(wr), 32'(exp_wr));
      chk({tag, " a3"}, 32'(a3), 32'(exp_a3));
      chk({tag, " div0"}, 32'(div0), 32'(exp_div0));
      chk({tag, " wrenable pulses"}, 32'(wen), (exp_a3 != 3'd0) ? 32'd1 : 32'd0);
      chk({tag, " busy held"}, 32'(busy_ok), 32'd1);
    end
  endtask

  // One edge after WB: back in IDLE, strobes low, result and address held.
  task automatic after_wb(input logic [15:0] exp_wr, input logic [2:0] exp_a3, input string tag);
    @(posedge clk); #1;
    chk({tag, " post done"}, 32'(done), 32'd0);
    chk({tag, " post wrenable"}, 32'(wrenable), 32'd0);
    chk({tag, " post div0"}, 32'(div0), 32'd0);
    chk({tag, " post busy"}, 32'(busy), 32'd0);
    chk({tag, " post wr held"}, 32'(wr), 32'(exp_wr));
    chk({tag, " post a3 held"}, 32'(a3), 32'(exp_a3));
  endtask

  initial begin
    vec_t vecs[9];
    logic [16:0] m;
    logic [1:0]  ro;
    logic [15:0] ra, rb;
    logic [2:0]  rd;
    int nd, nw;

    vecs[0] = '{2'b00, 16'h1234, 16'h0010, 3'd3, 16'h2340, 1'b0};
    vecs[1] = '{2'b01, 16'hFFFF, 16'hFFFF, 3'd5, 16'hFFFE, 1'b0};
    vecs[2] = '{2'b00, 16'hFFFF, 16'hFFFF, 3'd5, 16'h0001, 1'b0};
    vecs[3] = '{2'b10, 16'd100,  16'd7,    3'd2, 16'h000E, 1'b0};
    vecs[4] = '{2'b11, 16'd100,  16'd7,    3'd2, 16'h0002, 1'b0};
    vecs[5] = '{2'b10, 16'h00AB, 16'h0000, 3'd1, 16'hFFFF, 1'b1};
    vecs[6] = '{2'b11, 16'h00AB, 16'h0000, 3'd1, 16'h00AB, 1'b1};
    vecs[7] = '{2'b11, 16'h0005, 16'h0009, 3'd7, 16'h0005, 1'b0};
    vecs[8] = '{2'b10, 16'hFFFF, 16'h0001, 3'd4, 16'hFFFF, 1'b0};

    reset = 1'b1; start = 1'b0; op = '0; srca = '0; srcb = '0; dest = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset div0", 32'(div0), 32'd0);
    chk("reset wrenable", 32'(wrenable), 32'd0);
    chk("reset wr", 32'(wr), 32'd0);
    chk("reset a3", 32'(a3), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed vectors.
    for (int i = 0; i < 9; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].d);
      check_result(0, vecs[i].exp_wr, vecs[i].exp_div0, vecs[i].d, $sformatf("vec%0d", i));
      after_wb(vecs[i].exp_wr, vecs[i].d, $sformatf("vec%0d", i));
    end

    // Start held through WB is ignored there, accepted on the following IDLE edge.
    launch(2'b00, 16'd3, 16'd5, 3'd2);
    check_result(0, 16'd15, 1'b0, 3'd2, "b2b first");
    op = 2'b00; srca = 16'd7; srcb = 16'd7; dest = 3'd4; start = 1'b1;
    @(posedge clk); #1;
    chk("start in WB ignored", 32'(busy), 32'd0);
    chk("idle wr held", 32'(wr), 32'd15);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b accepted", 32'(busy), 32'd1);
    check_result(0, 16'd49, 1'b0, 3'd4, "b2b second");
    after_wb(16'd49, 3'd4, "b2b second");

    // dest=0 with a second start pulsed mid-run.
    launch(2'b00, 16'd3, 16'd4, 3'd0);
    repeat (4) @(posedge clk);
    #1;
    op = 2'b01; srca = 16'hFFFF; srcb = 16'hFFFF; dest = 3'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_result(5, 16'd12, 1'b0, 3'd0, "dest0");
    after_wb(16'd12, 3'd0, "dest0");
    nd = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (done || busy) nd++;
    end
    chk("dest0 second start ignored", 32'(nd), 32'd0);

    // Reset eight cycles into a run aborts with no write.
    launch(2'b10, 16'd1000, 16'd3, 3'd6);
    nd = 0; nw = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (done) nd++;
      if (wrenable) nw++;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort wr cleared", 32'(wr), 32'd0);
    chk("abort a3 cleared", 32'(a3), 32'd0);
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (done) nd++;
      if (wrenable) nw++;
    end
    chk("abort done pulses", 32'(nd), 32'd0);
    chk("abort wrenable pulses", 32'(nw), 32'd0);

    // Reset outranks start on the same edge.
    reset = 1'b1; start = 1'b1; op = 2'b00; srca = 16'd2; srcb = 16'd2; dest = 3'd1;
    @(posedge clk); #1;
    chk("reset over start", 32'(busy), 32'd0);
    reset = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("reset over start idle", 32'(busy), 32'd0);

    // Reset during WB: the WB cycle stands, IDLE follows.
    launch(2'b00, 16'd6, 16'd7, 3'd3);
    check_result(0, 16'd42, 1'b0, 3'd3, "wb reset");
    reset = 1'b1;
    #1;
    chk("wb reset wrenable kept", 32'(wrenable), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("wb reset busy", 32'(busy), 32'd0);
    chk("wb reset done", 32'(done), 32'd0);

    // Random operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom);
      ra = 16'($urandom);
      if (i % 8 == 0)                      rb = 16'd0;
      else if ($urandom_range(0, 3) == 0)  rb = 16'($urandom_range(1, 15));
      else                                 rb = 16'($urandom);
      rd = 3'($urandom);
      m  = model(ro, ra, rb);
      launch(ro, ra, rb, rd);
      check_result(0, m[15:0], m[16], rd, $sformatf("rnd%0d op%0d %0h,%0h", i, ro, ra, rb));
      after_wb(m[15:0], rd, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
